// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, frame constants and
// the debug view. Both the host transmitter and the receiver import these.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        DATA,
        PARITY,
        STOP,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam int PS2_FRAME_BITS         = 11;
    localparam int PS2_DATA_BITS          = 8;
    localparam int PS2_INHIBIT_CYCLES_DEF = 5000;
    localparam int PS2_TIMEOUT_CYCLES_DEF = 1000000;

    typedef struct packed {
        ps2_state_e  state;
        logic [3:0]  bit_cnt;
        logic        clk_sync;
        logic        dat_sync;
        logic        clk_fall;
        logic        dat_fall;
    } ps2_tx_dbg_t;

    // Odd parity: the bit that makes the total count of ones odd.
    function automatic logic ps2_odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one PS/2 line with falling-edge detection
// (synced value 1 then 0 on consecutive cycles).
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Idle PS/2 lines float high, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout = sync_q;
    assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, clocked-out
// frame driven by the device clock, ack check and wait for idle bus.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEF
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic        tx_done,
    output logic        tx_error,
    output logic        busy,
    inout  wire         PS2_CLK,
    inout  wire         PS2_DAT,
    output ps2_tx_dbg_t dbg
);

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

    ps2_state_e       state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic             clk_oe_q, clk_oe_d;
    logic             dat_oe_q, dat_oe_d;
    logic             tx_done_q, tx_done_d;
    logic             tx_error_q, tx_error_d;

    logic clk_s, clk_fall;
    logic dat_s, dat_fall;
    logic timed_state;

    ps2_sync_edge u_clk_sync (
        .clk   (CLOCK_50),
        .rst_n (resetn),
        .din   (PS2_CLK),
        .dout  (clk_s),
        .fall  (clk_fall)
    );

    ps2_sync_edge u_dat_sync (
        .clk   (CLOCK_50),
        .rst_n (resetn),
        .din   (PS2_DAT),
        .dout  (dat_s),
        .fall  (dat_fall)
    );

    assign timed_state = (state_q != IDLE) && (state_q != INHIBIT);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        bit_cnt_d  = bit_cnt_q;
        inh_cnt_d  = inh_cnt_q;
        clk_oe_d   = clk_oe_q;
        dat_oe_d   = dat_oe_q;
        tx_done_d  = 1'b0;
        tx_error_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    shift_d   = cmd_data;
                    parity_d  = ps2_odd_parity(cmd_data);
                    bit_cnt_d = '0;
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    dat_oe_d  = 1'b0;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b0;
                    dat_oe_d  = 1'b1;
                    state_d   = START;
                end else begin
                    inh_cnt_d = inh_cnt_q + INH_W'(1);
                end
            end
            START, DATA: begin
                if (clk_fall) begin
                    dat_oe_d  = ~shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (state_q == START)
                        state_d = DATA;
                    else if (bit_cnt_q == 4'(PS2_DATA_BITS - 1))
                        state_d = PARITY;
                end
            end
            PARITY: begin
                if (clk_fall) begin
                    dat_oe_d  = ~parity_q;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (clk_fall) begin
                    dat_oe_d  = 1'b0;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    state_d   = ACK;
                end
            end
            ACK: begin
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (!dat_s) begin
                        state_d = WAIT_IDLE;
                    end else begin
                        tx_error_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (clk_s && dat_s) begin
                    tx_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Timeout only fires when the state made no progress this cycle, so it
        // can never coincide with a tx_done or an ack-failure pulse.
        if (timed_state && (state_d == state_q) && !clk_fall && (to_cnt_q == TO_LAST)) begin
            tx_error_d = 1'b1;
            clk_oe_d   = 1'b0;
            dat_oe_d   = 1'b0;
            state_d    = IDLE;
        end

        if (!timed_state || (state_d != state_q) || clk_fall)
            to_cnt_d = '0;
        else
            to_cnt_d = to_cnt_q + TO_W'(1);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= '0;
            to_cnt_q   <= '0;
            inh_cnt_q  <= '0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            bit_cnt_q  <= bit_cnt_d;
            to_cnt_q   <= to_cnt_d;
            inh_cnt_q  <= inh_cnt_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            tx_done_q  <= tx_done_d;
            tx_error_q <= tx_error_d;
        end
    end

    assign PS2_CLK = clk_oe_q ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_oe_q ? 1'b0 : 1'bz;

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign tx_done   = tx_done_q;
    assign tx_error  = tx_error_q;

    assign dbg = '{state:    state_q,
                   bit_cnt:  bit_cnt_q,
                   clk_sync: clk_s,
                   dat_sync: dat_s,
                   clk_fall: clk_fall,
                   dat_fall: dat_fall};

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks frames out of the
// host, with ack, no-ack, stalled-clock and mid-frame reset scenarios.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INHIBIT = 5000;
    localparam int TIMEOUT = 2000;
    localparam int HALF    = 20;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  cmd_data;
    logic        cmd_valid;
    logic        cmd_ready, tx_done, tx_error, busy;
    ps2_tx_dbg_t dbg;

    wire ps2_clk;
    wire ps2_dat;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    always #10 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .CLOCK_50  (clk),
        .resetn    (resetn),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .tx_done   (tx_done),
        .tx_error  (tx_error),
        .busy      (busy),
        .PS2_CLK   (ps2_clk),
        .PS2_DAT   (ps2_dat),
        .dbg       (dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cnt  = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int last_fall_cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) acc_cnt++;
        if (tx_done) done_cnt++;
        if (tx_error) err_cnt++;
        if (tx_done && tx_error) both_cnt++;
    end

    initial begin
        #(400000 * 20);
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Counts cycles with PS2_CLK held low until the host's start bit appears.
    task automatic wait_start(output int inh_len, output logic ok);
        inh_len = 0;
        ok      = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (ps2_clk === 1'b0) begin
                inh_len++;
            end else if (ps2_dat === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Device side: n_falls clock pulses, sampling PS2_DAT while the clock is high.
    task automatic dev_frame(input logic do_ack, input int n_falls,
                             output logic [7:0] rx_byte, output logic rx_par,
                             output logic rx_stop, output int inh_len);
        logic        ok;
        logic [10:0] bits;
        bits = '0;
        wait_start(inh_len, ok);
        check("start_seen", {31'b0, ok}, 32'd1);
        @(posedge clk); #1;
        for (int i = 1; i <= n_falls; i++) begin
            repeat (HALF) @(posedge clk);
            #1;
            dev_clk_low   = 1'b1;
            last_fall_cyc = cyc;
            repeat (HALF) @(posedge clk);
            #1;
            bits[i-1]   = ps2_dat;
            dev_clk_low = 1'b0;
            if (i == 11) dev_dat_low = 1'b0;
            if (i == 10) begin
                repeat (HALF / 2) @(posedge clk);
                #1;
                dev_dat_low = do_ack;
            end
        end
        rx_byte = bits[7:0];
        rx_par  = bits[8];
        rx_stop = bits[9];
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk); #1;
            if (tx_done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        cmd_data  = b;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    logic [7:0] rx_byte;
    logic       rx_par, rx_stop;
    int         inh_len, lat, acc_base, seen;

    initial begin
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        #25;
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_busy",      {31'b0, busy},      32'd0);
        check("rst_tx_done",   {31'b0, tx_done},   32'd0);
        check("rst_tx_error",  {31'b0, tx_error},  32'd0);
        check("rst_ps2_clk",   {31'b0, ps2_clk},   32'd1);
        check("rst_ps2_dat",   {31'b0, ps2_dat},   32'd1);
        check("rst_state",     {29'b0, dbg.state}, {29'b0, IDLE});
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // 8'hF4 with ack: bits 0,0,1,0,1,1,1,1 LSB first, parity 0, stop 1
        send(8'hF4);
        check("f4_busy_after_accept",  {31'b0, busy},      32'd1);
        check("f4_ready_after_accept", {31'b0, cmd_ready}, 32'd0);
        dev_frame(1'b1, 11, rx_byte, rx_par, rx_stop, inh_len);
        check("f4_byte",   {24'b0, rx_byte}, 32'h0000_00F4);
        check("f4_parity", {31'b0, rx_par},  32'd0);
        check("f4_stop",   {31'b0, rx_stop}, 32'd1);
        check("f4_inhibit_len", inh_len, INHIBIT);
        wait_done(lat);
        check("f4_done_latency", lat, 32'd3);
        @(posedge clk); #1;
        check("f4_done_one_cycle", {31'b0, tx_done}, 32'd0);
        check("f4_done_cnt", done_cnt, 32'd1);
        check("f4_err_cnt",  err_cnt,  32'd0);

        // 8'hFF: parity 1, clock held low exactly INHIBIT cycles before start
        send(8'hFF);
        dev_frame(1'b1, 11, rx_byte, rx_par, rx_stop, inh_len);
        check("ff_inhibit_len", inh_len, INHIBIT);
        check("ff_byte",   {24'b0, rx_byte}, 32'h0000_00FF);
        check("ff_parity", {31'b0, rx_par},  32'd1);
        check("ff_stop",   {31'b0, rx_stop}, 32'd1);
        wait_done(lat);
        check("ff_done_latency", lat, 32'd3);

        // No ack from the device: error pulse, no done
        repeat (5) @(posedge clk);
        #1;
        send(8'hA5);
        dev_frame(1'b0, 11, rx_byte, rx_par, rx_stop, inh_len);
        check("nack_byte",   {24'b0, rx_byte}, 32'h0000_00A5);
        check("nack_parity", {31'b0, rx_par},  32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("nack_err_cnt",  err_cnt,  32'd1);
        check("nack_done_cnt", done_cnt, 32'd2);
        check("nack_busy",     {31'b0, busy}, 32'd0);

        // Device stops clocking after bit 3 (4th falling edge); 8'h30 has bit3 = 0
        send(8'h30);
        dev_frame(1'b1, 4, rx_byte, rx_par, rx_stop, inh_len);
        check("to_dat_held_low", {31'b0, ps2_dat}, 32'd0);
        check("to_busy_stalled", {31'b0, busy},    32'd1);
        seen = 0;
        for (int k = 0; k < TIMEOUT + 200; k++) begin
            @(posedge clk); #1;
            if (tx_error === 1'b1) begin
                seen = 1;
                break;
            end
        end
        check("to_error_seen", seen, 32'd1);
        // Two synchronizer stages plus the registered fall precede the timeout count
        check("to_error_delay", cyc - last_fall_cyc, TIMEOUT + 3);
        check("to_ps2_clk_released", {31'b0, ps2_clk}, 32'd1);
        check("to_ps2_dat_released", {31'b0, ps2_dat}, 32'd1);
        @(posedge clk); #1;
        check("to_error_one_cycle", {31'b0, tx_error},  32'd0);
        check("to_cmd_ready",       {31'b0, cmd_ready}, 32'd1);
        check("to_done_cnt", done_cnt, 32'd2);

        // Reset asserted in the middle of DATA with the host driving PS2_DAT low
        send(8'h00);
        dev_frame(1'b1, 3, rx_byte, rx_par, rx_stop, inh_len);
        check("rmid_dat_low_before", {31'b0, ps2_dat}, 32'd0);
        @(negedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("rmid_ps2_clk",   {31'b0, ps2_clk},   32'd1);
        check("rmid_ps2_dat",   {31'b0, ps2_dat},   32'd1);
        check("rmid_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("rmid_busy",      {31'b0, busy},      32'd0);
        check("rmid_tx_done",   {31'b0, tx_done},   32'd0);
        check("rmid_tx_error",  {31'b0, tx_error},  32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("rmid_err_cnt",  err_cnt,  32'd2);
        check("rmid_done_cnt", done_cnt, 32'd2);

        // cmd_valid held high across two transfers of 8'hED
        acc_base  = acc_cnt;
        cmd_data  = 8'hED;
        cmd_valid = 1'b1;
        dev_frame(1'b1, 11, rx_byte, rx_par, rx_stop, inh_len);
        check("ed1_byte",   {24'b0, rx_byte}, 32'h0000_00ED);
        check("ed1_parity", {31'b0, rx_par},  32'd1);
        wait_done(lat);
        check("ed1_done_latency", lat, 32'd3);
        check("ed1_accepts", acc_cnt - acc_base, 32'd1);
        dev_frame(1'b1, 11, rx_byte, rx_par, rx_stop, inh_len);
        check("ed2_byte", {24'b0, rx_byte}, 32'h0000_00ED);
        check("ed2_inhibit_len", inh_len, INHIBIT);
        wait_done(lat);
        cmd_valid = 1'b0;
        check("ed2_done_latency", lat, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        check("ed2_accepts",  acc_cnt - acc_base, 32'd2);
        check("ed2_busy",     {31'b0, busy},      32'd0);
        check("ed2_done_cnt", done_cnt, 32'd4);
        check("never_done_and_error", both_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
